// File: rtl/rgb_bitonic_ranker.sv
// -----------------------------------------------------------------------------
// rgb_bitonic_ranker
//
// Sorts CH independent channels of N = 2**N_LOG2 unsigned keys with a
// time-multiplexed bitonic network (one compare-exchange substage per clock,
// all channels in parallel) and reports, per channel, the sorted index order
// and its inverse permutation (the rank of every input element).
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_start    start request, only honoured in IDLE
//   i_descend  0 = ascending, 1 = descending; latched together with i_start
//   i_data     keys, element e of channel c at [(c*N+e)*DATA_W +: DATA_W]
//   o_busy     high while sorting and ranking
//   o_done     one-cycle pulse when o_index / o_rank are fresh
//   o_index    slot k of channel c at [(c*N+k)*N_LOG2 +: N_LOG2]:
//              input element holding the k-th key in sorted order
//   o_rank     slot e of channel c: sorted position of input element e
// -----------------------------------------------------------------------------
module rgb_bitonic_ranker #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 8,
    parameter int CH     = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_descend,
    input  logic [CH*(1<<N_LOG2)*DATA_W-1:0] i_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [CH*(1<<N_LOG2)*N_LOG2-1:0] o_index,
    output logic [CH*(1<<N_LOG2)*N_LOG2-1:0] o_rank
);

    localparam int N  = 1 << N_LOG2;
    // Phase/substage counters only ever hold 0..N_LOG2-1.
    localparam int CW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_RANK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                    state_r;
    logic [DATA_W-1:0]         key_r     [CH][N];
    logic [N_LOG2-1:0]         idx_r     [CH][N];
    logic [CW-1:0]             phase_r;
    logic [CW-1:0]             sub_r;
    logic                      desc_r;
    logic                      busy_r;
    logic                      done_r;
    logic [CH*N*N_LOG2-1:0]    index_out_r;
    logic [CH*N*N_LOG2-1:0]    rank_out_r;

    logic [N_LOG2-1:0]         peer_mask_s;
    logic [DATA_W-1:0]         key_nxt_s [CH][N];
    logic [N_LOG2-1:0]         idx_nxt_s [CH][N];
    logic [N_LOG2-1:0]         rank_s    [CH][N];
    logic [CH*N*N_LOG2-1:0]    index_pack_s;
    logic [CH*N*N_LOG2-1:0]    rank_pack_s;

    // Partner of slot i is i XOR peer_mask_s: the merge-flip mirrors inside a
    // block of 2^(p+1) (XOR with 2^(p+1)-1), a half-cleaner pairs i with i+2^q.
    always_comb begin
        peer_mask_s = '0;
        if (sub_r == phase_r) begin
            // 2^p | (2^p - 1) == 2^(p+1) - 1 without overflowing N_LOG2 bits
            peer_mask_s = (N_LOG2'(1) << phase_r) | ((N_LOG2'(1) << phase_r) - N_LOG2'(1));
        end else begin
            peer_mask_s = N_LOG2'(1) << sub_r;
        end
    end

    // One compare-exchange substage across all channels; each slot picks its
    // own or its partner's entry depending on the pair's swap decision.
    always_comb begin : p_network
        logic [N_LOG2-1:0] pos_v;
        logic [N_LOG2-1:0] peer_v;
        logic [N_LOG2-1:0] lo_v;
        logic [N_LOG2-1:0] hi_v;
        logic              swap_v;
        pos_v  = '0;
        peer_v = '0;
        lo_v   = '0;
        hi_v   = '0;
        swap_v = 1'b0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) begin
                pos_v  = N_LOG2'(i);
                peer_v = pos_v ^ peer_mask_s;
                lo_v   = (pos_v < peer_v) ? pos_v : peer_v;
                hi_v   = (pos_v < peer_v) ? peer_v : pos_v;
                if (desc_r) begin
                    swap_v = key_r[c][lo_v] < key_r[c][hi_v];
                end else begin
                    swap_v = key_r[c][lo_v] > key_r[c][hi_v];
                end
                key_nxt_s[c][i] = swap_v ? key_r[c][peer_v] : key_r[c][i];
                idx_nxt_s[c][i] = swap_v ? idx_r[c][peer_v] : idx_r[c][i];
            end
        end
    end

    // Inverse permutation: the element sitting in sorted slot k has rank k.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) begin
                rank_s[c][k] = '0;
            end
        end
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) begin
                rank_s[c][idx_r[c][k]] = N_LOG2'(k);
            end
        end
    end

    // Flatten the index order and ranks onto the output bus layout.
    always_comb begin
        index_pack_s = '0;
        rank_pack_s  = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) begin
                index_pack_s[(c*N+k)*N_LOG2 +: N_LOG2] = idx_r[c][k];
                rank_pack_s[(c*N+k)*N_LOG2 +: N_LOG2]  = rank_s[c][k];
            end
        end
    end

    // Control FSM, working key/index registers and registered results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            phase_r     <= '0;
            sub_r       <= '0;
            desc_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            index_out_r <= '0;
            rank_out_r  <= '0;
            for (int c = 0; c < CH; c++) begin
                for (int e = 0; e < N; e++) begin
                    key_r[c][e] <= '0;
                    idx_r[c][e] <= '0;
                end
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_start) begin
                        for (int c = 0; c < CH; c++) begin
                            for (int e = 0; e < N; e++) begin
                                key_r[c][e] <= i_data[(c*N+e)*DATA_W +: DATA_W];
                                idx_r[c][e] <= N_LOG2'(e);
                            end
                        end
                        desc_r  <= i_descend;
                        phase_r <= '0;
                        sub_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SORT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SORT: begin
                    for (int c = 0; c < CH; c++) begin
                        for (int e = 0; e < N; e++) begin
                            key_r[c][e] <= key_nxt_s[c][e];
                            idx_r[c][e] <= idx_nxt_s[c][e];
                        end
                    end
                    if (sub_r == CW'(0)) begin
                        if (phase_r == CW'(N_LOG2 - 1)) begin
                            state_r <= ST_RANK;
                        end else begin
                            phase_r <= phase_r + CW'(1);
                            sub_r   <= phase_r + CW'(1);
                        end
                    end else begin
                        sub_r <= sub_r - CW'(1);
                    end
                end
                ST_RANK: begin
                    index_out_r <= index_pack_s;
                    rank_out_r  <= rank_pack_s;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_index = index_out_r;
    assign o_rank  = rank_out_r;

endmodule

// File: tb/tb_rgb_bitonic_ranker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rgb_bitonic_ranker: a table of directed/random
// vectors on the default configuration (expected results queued at start and
// compared when o_done pulses), hand-written sequences for held start,
// back-to-back runs and mid-sort reset, plus random regressions on
// single-channel instances with N_LOG2 = 1, 3, 5 and 12-bit keys.
// -----------------------------------------------------------------------------
module tb_rgb_bitonic_ranker;

    localparam int NL = 4;
    localparam int N  = 16;
    localparam int W  = 8;
    localparam int C  = 3;
    localparam int S  = NL * (NL + 1) / 2;

    typedef struct {
        logic [C*N*W-1:0]  data;
        bit                desc;
        bit                toggle;
        bit                exact;
        logic [C*N*NL-1:0] idx;
        logic [C*N*NL-1:0] rnk;
    } vec_t;

    typedef struct {
        bit                exact;
        logic [C*N*NL-1:0] idx;
        logic [C*N*NL-1:0] rnk;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              reg_rst_n;
    logic              start;
    logic              descend;
    logic [C*N*W-1:0]  data;
    logic              busy;
    logic              done;
    logic [C*N*NL-1:0] index;
    logic [C*N*NL-1:0] rank;

    int   errors;
    int   checks;
    exp_t sb_q [$];
    vec_t tbl [6];

    rgb_bitonic_ranker #(.N_LOG2(NL), .DATA_W(W), .CH(C)) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_descend (descend),
        .i_data    (data),
        .o_busy    (busy),
        .o_done    (done),
        .o_index   (index),
        .o_rank    (rank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: rank = number of keys strictly before this one in the order.
    function automatic void model3(input logic [C*N*W-1:0] d, input bit desc,
                                   output logic [C*N*NL-1:0] idx, output logic [C*N*NL-1:0] rnk);
        int r;
        logic [W-1:0] ke;
        logic [W-1:0] kj;
        idx = '0;
        rnk = '0;
        for (int c = 0; c < C; c++) begin
            for (int e = 0; e < N; e++) begin
                r  = 0;
                ke = d[(c*N+e)*W +: W];
                for (int j = 0; j < N; j++) begin
                    kj = d[(c*N+j)*W +: W];
                    if (desc ? (kj > ke) : (kj < ke)) r++;
                end
                rnk[(c*N+e)*NL +: NL] = NL'(r);
                idx[(c*N+r)*NL +: NL] = NL'(e);
            end
        end
    endfunction

    function automatic logic [C*N*W-1:0] rand_distinct();
        logic [C*N*W-1:0] d;
        bit used [256];
        int v;
        d = '0;
        for (int c = 0; c < C; c++) begin
            for (int i = 0; i < 256; i++) used[i] = 1'b0;
            for (int e = 0; e < N; e++) begin
                v = $urandom_range(0, 255);
                while (used[v]) v = (v + 1) % 256;
                used[v] = 1'b1;
                d[(c*N+e)*W +: W] = W'(v);
            end
        end
        return d;
    endfunction

    // Scoreboard: every o_done pops the oldest expectation and compares.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        int   s;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done with empty queue, required no done");
            end else begin
                e = sb_q.pop_front();
                if (e.exact) begin
                    chk("sb_index", index, e.idx);
                    chk("sb_rank", rank, e.rnk);
                end else begin
                    for (int c = 0; c < C; c++) begin
                        ok = !$isunknown(index) && !$isunknown(rank);
                        for (int k = 0; k < N && ok; k++) begin
                            s = int'(index[(c*N+k)*NL +: NL]);
                            if (rank[(c*N+s)*NL +: NL] != NL'(k)) ok = 1'b0;
                        end
                        chk_int($sformatf("sb_perm_inverse_ch%0d", c), int'(ok), 1);
                    end
                end
            end
        end
    end

    // Waits for o_done, counting busy cycles; cyc 0 is the cycle after the
    // start-accepting edge. lat stays -1 if the bound expires.
    task automatic wait_done(input bit toggle, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (toggle && cyc == 3) descend = ~descend;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic run_main(input vec_t v, input string nm);
        exp_t e;
        int   lat;
        int   bcnt;
        @(negedge clk);
        data    = v.data;
        descend = v.desc;
        start   = 1'b1;
        e.exact = v.exact;
        e.idx   = v.idx;
        e.rnk   = v.rnk;
        sb_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(v.toggle, lat, bcnt);
        chk_int({nm, "_latency"}, lat, S + 1);
        chk_int({nm, "_busy_cycles"}, bcnt, S + 1);
    endtask

    // Single-channel random regressions at other sizes.
    genvar g;
    for (g = 0; g < 3; g++) begin : g_reg
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
        localparam int RN = 1 << RL;
        localparam int RS = RL * (RL + 1) / 2;

        logic              r_start;
        logic              r_desc;
        logic [RN*12-1:0]  r_data;
        logic              r_busy;
        logic              r_done;
        logic [RN*RL-1:0]  r_index;
        logic [RN*RL-1:0]  r_rank;
        bit                fin;

        rgb_bitonic_ranker #(.N_LOG2(RL), .DATA_W(12), .CH(1)) u_reg (
            .i_clk     (clk),
            .i_rst_n   (reg_rst_n),
            .i_start   (r_start),
            .i_descend (r_desc),
            .i_data    (r_data),
            .o_busy    (r_busy),
            .o_done    (r_done),
            .o_index   (r_index),
            .o_rank    (r_rank)
        );

        initial begin
            int               kk [RN];
            logic [RN*RL-1:0] exp_idx;
            logic [RN*RL-1:0] exp_rnk;
            bit               dsc;
            bit               dup;
            int               r;
            int               lat;
            fin     = 1'b0;
            r_start = 1'b0;
            r_desc  = 1'b0;
            r_data  = '0;
            @(posedge reg_rst_n);
            for (int v = 0; v < 1000; v++) begin
                for (int e = 0; e < RN; e++) begin
                    do begin
                        kk[e] = $urandom_range(0, 4095);
                        dup   = 1'b0;
                        for (int j = 0; j < e; j++) if (kk[j] == kk[e]) dup = 1'b1;
                    end while (dup);
                end
                dsc     = 1'($urandom_range(0, 1));
                exp_idx = '0;
                exp_rnk = '0;
                for (int e = 0; e < RN; e++) begin
                    r = 0;
                    for (int j = 0; j < RN; j++) if (dsc ? (kk[j] > kk[e]) : (kk[j] < kk[e])) r++;
                    exp_rnk[e*RL +: RL] = RL'(r);
                    exp_idx[r*RL +: RL] = RL'(e);
                end
                @(negedge clk);
                for (int e = 0; e < RN; e++) r_data[e*12 +: 12] = 12'(kk[e]);
                r_desc  = dsc;
                r_start = 1'b1;
                @(posedge clk);
                #1 r_start = 1'b0;
                lat = -1;
                for (int cyc = 0; cyc < 100; cyc++) begin
                    @(negedge clk);
                    if (r_done === 1'b1) begin
                        lat = cyc;
                        break;
                    end
                end
                chk_int($sformatf("reg_nlog%0d_v%0d_latency", RL, v), lat, RS + 1);
                chk($sformatf("reg_nlog%0d_v%0d_index", RL, v), 192'(r_index), 192'(exp_idx));
                chk($sformatf("reg_nlog%0d_v%0d_rank", RL, v), 192'(r_rank), 192'(exp_rnk));
            end
            fin = 1'b1;
        end
    end

    initial begin
        logic [C*N*W-1:0]  d;
        logic [C*N*NL-1:0] lastc;
        logic [63:0]       rev_v;
        logic [63:0]       fwd_v;
        exp_t              e;
        vec_t              vr;
        int                lat;
        int                bcnt;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        reg_rst_n = 1'b0;
        start     = 1'b0;
        descend   = 1'b0;
        data      = '0;

        // Vector table: inputs first, expected outputs filled by the model.
        d = '0;
        for (int k = 0; k < N; k++) begin
            d[(0*N+k)*W +: W] = W'(15 - k);
            d[(1*N+k)*W +: W] = W'(k);
            d[(2*N+k)*W +: W] = W'(((k * 7) % 16) * 16);
            rev_v[k*NL +: NL] = NL'(15 - k);
            fwd_v[k*NL +: NL] = NL'(k);
        end
        tbl[0] = '{data: d, desc: 1'b0, toggle: 1'b0, exact: 1'b1, idx: '0, rnk: '0};
        tbl[1] = '{data: d, desc: 1'b1, toggle: 1'b1, exact: 1'b1, idx: '0, rnk: '0};
        d = '0;
        for (int k = 0; k < C * N; k++) d[k*W +: W] = 8'hAA;
        tbl[2] = '{data: d, desc: 1'b0, toggle: 1'b0, exact: 1'b0, idx: '0, rnk: '0};
        tbl[3] = '{data: d, desc: 1'b1, toggle: 1'b0, exact: 1'b0, idx: '0, rnk: '0};
        tbl[4] = '{data: rand_distinct(), desc: 1'b0, toggle: 1'b0, exact: 1'b1, idx: '0, rnk: '0};
        tbl[5] = '{data: rand_distinct(), desc: 1'b1, toggle: 1'b1, exact: 1'b1, idx: '0, rnk: '0};
        for (int i = 0; i < 6; i++) model3(tbl[i].data, tbl[i].desc, tbl[i].idx, tbl[i].rnk);

        repeat (3) @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk("reset_index", index, '0);
        chk("reset_rank", rank, '0);
        rst_n     = 1'b1;
        reg_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_main(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("vec0_ch0_index_rev", 192'(index[63:0]), 192'(rev_v));
                chk("vec0_ch1_index_fwd", 192'(index[127:64]), 192'(fwd_v));
                chk("vec0_ch0_rank_rev", 192'(rank[63:0]), 192'(rev_v));
            end else if (i == 1) begin
                chk("vec1_ch0_index_fwd", 192'(index[63:0]), 192'(fwd_v));
                chk("vec1_ch1_index_rev", 192'(index[127:64]), 192'(rev_v));
            end
        end

        // i_start held through a whole run, then back-to-back second run.
        @(negedge clk);
        data    = tbl[4].data;
        descend = 1'b0;
        start   = 1'b1;
        e = '{exact: 1'b1, idx: tbl[4].idx, rnk: tbl[4].rnk};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        wait_done(1'b0, lat, bcnt);
        chk_int("held_run1_latency", lat, S + 1);
        data = tbl[0].data;
        e = '{exact: 1'b1, idx: tbl[0].idx, rnk: tbl[0].rnk};
        sb_q.push_back(e);
        @(negedge clk);
        chk_int("held_idle_busy", int'(busy), 0);
        chk("held_idle_hold_index", index, tbl[4].idx);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk_int("held_restart_busy", int'(busy), 1);
        chk("held_sort_hold_index", index, tbl[4].idx);
        chk("held_sort_hold_rank", rank, tbl[4].rnk);
        wait_done(1'b0, lat, bcnt);
        chk_int("held_run2_latency", lat, S);
        lastc = index;

        // Reset in the middle of sorting; outputs clear asynchronously.
        @(negedge clk);
        data    = tbl[5].data;
        descend = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_int("midreset_busy", int'(busy), 0);
        chk_int("midreset_done", int'(done), 0);
        chk("midreset_index", index, '0);
        chk("midreset_rank", rank, '0);
        chk_int("midreset_prior_nonzero", int'(lastc != '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        vr = '{data: rand_distinct(), desc: 1'b0, toggle: 1'b0, exact: 1'b1, idx: '0, rnk: '0};
        model3(vr.data, vr.desc, vr.idx, vr.rnk);
        run_main(vr, "post_reset");

        for (int i = 0; i < 60000; i++) begin
            if (g_reg[0].fin && g_reg[1].fin && g_reg[2].fin) break;
            @(negedge clk);
        end
        chk_int("regression_finished",
                int'(g_reg[0].fin && g_reg[1].fin && g_reg[2].fin), 1);
        chk_int("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
